// File: rtl/neosd_pkg.sv
// Shared types and CRC16 helper for the SD DAT transmit sequencer.
// The STATUS/BUSY states exist only when NEOSD_DAT_BUSY_WAIT_EN is defined.
package neosd_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

`ifdef NEOSD_DAT_BUSY_WAIT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_DATA, S_CRC, S_END, S_STATUS, S_BUSY
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_DATA, S_CRC, S_END
    } state_t;
`endif

    // One CCITT CRC16 step, MSB-first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/neosd_dat_tx.sv
// SD DAT line block-write sequencer: start bit, payload, CRC16, end bit.
// Define NEOSD_DAT_BUSY_WAIT_EN to also collect the CRC status token and busy phase.
//
// state  | meaning
// IDLE   | line released, waiting for start_i
// FETCH  | first byte handshake into the shift register
// START  | drive the start bit on the next strobe
// DATA   | shift payload bits, reload at each byte boundary
// CRC    | shift out the 16 CRC bits
// END    | drive end bit, then release the line
// STATUS | wait for the card's CRC status token, capture 3 bits
// BUSY   | wait for the card to release DAT
module neosd_dat_tx
    import neosd_pkg::*;
#(
    parameter int BLKLEN_W = 10
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                clkstrb_i,
    input  logic                start_i,
    input  logic [BLKLEN_W-1:0] blklen_i,
    input  logic [7:0]          byte_i,
    input  logic                byte_valid_i,
    output logic                byte_ready_o,
    output logic [7:0]          sreg_data_o,
    output logic                sreg_load_o,
    output logic                sreg_shift_o,
    input  logic                sreg_bit_i,
    input  logic                sd_dat_i,
    output logic                sd_dat_o,
    output logic                sd_dat_oe_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [2:0]          status_o
);

    state_t              state, state_nxt;
    logic [BLKLEN_W-1:0] rem;
    logic [15:0]         crc;
    logic [3:0]          cnt;
    logic                dat, oe, err, done;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start_i) state_nxt = S_FETCH;
            S_FETCH: if (byte_valid_i) state_nxt = S_START;
            S_START: if (clkstrb_i) state_nxt = S_DATA;
            S_DATA: begin
                if (clkstrb_i && cnt == 4'd7) begin
                    if (rem == '0)        state_nxt = S_CRC;
                    else if (!byte_valid_i) state_nxt = S_END;
                end
            end
            S_CRC:   if (clkstrb_i && cnt == 4'd15) state_nxt = S_END;
`ifdef NEOSD_DAT_BUSY_WAIT_EN
            S_END:    if (clkstrb_i && cnt != 4'd0) state_nxt = S_STATUS;
            S_STATUS: if (clkstrb_i && cnt == 4'd4) state_nxt = S_BUSY;
            S_BUSY:   if (clkstrb_i && sd_dat_i) state_nxt = S_IDLE;
`else
            S_END:    if (clkstrb_i && cnt != 4'd0) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // At the 8th bit strobe the next byte is loaded instead of shifting.
    always_comb begin
        byte_ready_o = 1'b0;
        sreg_shift_o = 1'b0;
        unique case (state)
            S_FETCH: byte_ready_o = 1'b1;
            S_DATA: begin
                if (clkstrb_i) begin
                    if (cnt == 4'd7) byte_ready_o = (rem != '0);
                    else             sreg_shift_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rem  <= '0;
            crc  <= '0;
            cnt  <= '0;
            dat  <= 1'b1;
            oe   <= 1'b0;
            err  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        rem <= blklen_i;
                        crc <= '0;
                        err <= 1'b0;
                    end
                end
                S_FETCH: if (byte_valid_i) rem <= rem - BLKLEN_W'(1);
                S_START: begin
                    if (clkstrb_i) begin
                        dat <= 1'b0;
                        oe  <= 1'b1;
                        cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (clkstrb_i) begin
                        dat <= sreg_bit_i;
                        crc <= crc16_step(crc, sreg_bit_i);
                        if (cnt == 4'd7) begin
                            cnt <= '0;
                            if (rem != '0) begin
                                if (byte_valid_i) rem <= rem - BLKLEN_W'(1);
                                else              err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                S_CRC: begin
                    if (clkstrb_i) begin
                        dat <= crc[15];
                        crc <= {crc[14:0], 1'b0};
                        cnt <= cnt + 4'd1;
                    end
                end
                S_END: begin
                    if (clkstrb_i) begin
                        if (cnt == 4'd0) begin
                            dat <= 1'b1;
                            cnt <= 4'd1;
                        end else begin
                            oe  <= 1'b0;
                            cnt <= '0;
`ifndef NEOSD_DAT_BUSY_WAIT_EN
                            done <= 1'b1;
`endif
                        end
                    end
                end
`ifdef NEOSD_DAT_BUSY_WAIT_EN
                S_STATUS: begin
                    if (clkstrb_i) begin
                        if (cnt == 4'd0) begin
                            if (!sd_dat_i) cnt <= 4'd1;
                        end else if (cnt != 4'd4) begin
                            cnt <= cnt + 4'd1;
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                S_BUSY: if (clkstrb_i && sd_dat_i) done <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

`ifdef NEOSD_DAT_BUSY_WAIT_EN
    logic [2:0] status;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            status <= '0;
        end else if (state == S_STATUS && clkstrb_i && cnt != 4'd0 && cnt != 4'd4) begin
            status <= {status[1:0], sd_dat_i};
        end
    end

    assign status_o = status;
`else
    logic unused_sd_dat;
    assign unused_sd_dat = sd_dat_i;
    assign status_o      = 3'b000;
`endif

    assign sreg_data_o = byte_i;
    assign sreg_load_o = byte_valid_i & byte_ready_o;
    assign sd_dat_o    = dat;
    assign sd_dat_oe_o = oe;
    assign busy_o      = (state != S_IDLE);
    assign done_o      = done;
    assign err_o       = err;

endmodule

// File: tb/tb_neosd_dat_tx.sv
// Bench for neosd_dat_tx: models the shift register, byte source and card,
// and compares the captured DAT frame against a bit-list reference.
module tb_neosd_dat_tx;

    localparam int BW = 10;

    logic          clk = 1'b0, rstn = 1'b0, clkstrb = 1'b0, start = 1'b0;
    logic [BW-1:0] blklen = '0;
    logic [7:0]    byte_d = 8'h00;
    logic          byte_valid = 1'b0, sd_in = 1'b1;
    logic          byte_ready, sreg_load, sreg_shift, sreg_bit;
    logic [7:0]    sreg_data;
    logic          dat, oe, busy, done, err;
    logic [2:0]    status;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    neosd_dat_tx #(.BLKLEN_W(BW)) dut (
        .clk_i(clk), .rstn_i(rstn), .clkstrb_i(clkstrb), .start_i(start),
        .blklen_i(blklen), .byte_i(byte_d), .byte_valid_i(byte_valid),
        .byte_ready_o(byte_ready), .sreg_data_o(sreg_data), .sreg_load_o(sreg_load),
        .sreg_shift_o(sreg_shift), .sreg_bit_i(sreg_bit), .sd_dat_i(sd_in),
        .sd_dat_o(dat), .sd_dat_oe_o(oe), .busy_o(busy), .done_o(done),
        .err_o(err), .status_o(status)
    );

    // external 8-bit parallel-load / serial-shift register
    logic [7:0] sreg = 8'h00;
    always @(posedge clk) begin
        if (sreg_load)       sreg <= sreg_data;
        else if (sreg_shift) sreg <= {sreg[6:0], 1'b0};
    end
    assign sreg_bit = sreg[7];

    // strobe generator and byte source; handshakes observed mid-cycle
    int         period = 4, scnt = 0;
    logic [7:0] src[$];
    logic [7:0] blk[$];
    bit         withhold = 0, pop_pend = 0;
    int         hs_cnt = 0, hs_base = 0, load_strb = 0, both = 0;

    initial forever begin
        @(negedge clk);
        if (pop_pend && src.size() > 0) void'(src.pop_front());
        pop_pend = 0;
        scnt++;
        if (scnt >= period) begin clkstrb = 1'b1; scnt = 0; end
        else clkstrb = 1'b0;
        byte_valid = (src.size() > 0) && !(withhold && hs_cnt > hs_base);
        byte_d     = (src.size() > 0) ? src[0] : 8'h00;
        #1;
        if (byte_valid && byte_ready) begin hs_cnt++; pop_pend = 1; end
        if (sreg_load && clkstrb) load_strb++;
        if (sreg_load && sreg_shift) both++;
    end

    // line capture and card response (idle, token 0 010 1, five busy lows, release)
    bit cap[$];
    bit exp_q[$];
    int done_cnt = 0, done_base = 0, card_idx = 12;
    bit mon_s, prev_oe = 0;
    bit card_seq [0:11] = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1};

    always @(posedge clk) begin
        mon_s = clkstrb;
        #1;
        if (mon_s && oe) cap.push_back(dat);
        if (done) done_cnt++;
        if (mon_s && card_idx < 12) begin sd_in = card_seq[card_idx]; card_idx++; end
        if (prev_oe && !oe) begin sd_in = card_seq[0]; card_idx = 1; end
        prev_oe = oe;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // reference frame: start bit, payload MSB-first, CRC16 (x^16+x^12+x^5+1), end bit
    task automatic build_exp();
        logic [15:0] c;
        bit b;
        exp_q.delete();
        exp_q.push_back(1'b0);
        c = 16'h0000;
        foreach (blk[k]) begin
            for (int i = 7; i >= 0; i--) begin
                b = blk[k][i];
                exp_q.push_back(b);
                if (c[15] ^ b) c = (c << 1) ^ 16'h1021;
                else           c = c << 1;
            end
        end
        for (int i = 15; i >= 0; i--) exp_q.push_back(c[i]);
        exp_q.push_back(1'b1);
    endtask

    task automatic launch(input int n);
        cap.delete();
        src = blk;
        @(posedge clk); #2;
        done_base = done_cnt;
        hs_base   = hs_cnt;
        blklen    = BW'(n);
        start     = 1'b1;
        @(posedge clk); #2;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40000 && done_cnt == done_base; i++) begin
            @(posedge clk); #3;
        end
        repeat (3) @(posedge clk);
        #2;
        check({tag, "_done"}, done_cnt - done_base, 1);
    endtask

    task automatic check_frame(input string tag);
        int bad = -1;
        check({tag, "_len"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            if (cap[i] !== exp_q[i] && bad < 0) bad = i;
        check({tag, "_bits"}, bad, -1);
    endtask

    function automatic logic [15:0] line_word(input int first);
        logic [15:0] w = 16'h0000;
        for (int i = 0; i < 16; i++)
            w = {w[14:0], (first + i < cap.size()) ? cap[first + i] : 1'b0};
        return w;
    endfunction

    task automatic fill_random(input int n);
        blk.delete();
        for (int i = 0; i < n; i++) blk.push_back(8'($urandom));
    endtask

    initial begin
        int n, ls0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_dat", dat, 1);
        check("rst_oe", oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", byte_ready, 0);
        check("rst_shift", sreg_shift, 0);
        check("rst_status", status, 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // single zero byte
        blk = '{8'h00};
        build_exp();
        launch(1);
        wait_done("z1");
        check_frame("z1");
        check("z1_crc", line_word(9), 16'h0000);
        check("z1_err", err, 0);
        check("z1_busy", busy, 0);
`ifdef NEOSD_DAT_BUSY_WAIT_EN
        check("z1_status", status, 3'b010);
`else
        check("z1_status", status, 3'b000);
`endif

        // two bytes, reload on the 8th-bit strobe
        blk = '{8'hA5, 8'h3C};
        build_exp();
        ls0 = load_strb;
        launch(2);
        wait_done("ab");
        check_frame("ab");
        check("ab_payload", line_word(1), 16'hA53C);
        check("ab_load_on_strobe", load_strb - ls0, 1);
        check("ab_hs", hs_cnt - hs_base, 2);

        // full 512-byte block of 0xFF
        blk.delete();
        for (int i = 0; i < 512; i++) blk.push_back(8'hFF);
        build_exp();
        launch(512);
        wait_done("ff");
        check_frame("ff");
        check("ff_crc", line_word(1 + 4096), 16'h7FA1);
        check("ff_hs", hs_cnt - hs_base, 512);
        check("ff_driven", cap.size(), 1 + 4096 + 16 + 1);

        // random blocks and strobe spacing
        for (int t = 0; t < 5; t++) begin
            period = $urandom_range(6, 2);
            n = $urandom_range(16, 1);
            fill_random(n);
            build_exp();
            launch(n);
            wait_done("rnd");
            check_frame("rnd");
            check("rnd_hs", hs_cnt - hs_base, n);
        end
        period = 4;

        // underrun: second byte never arrives
        fill_random(3);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 7; i >= 0; i--) exp_q.push_back(blk[0][i]);
        exp_q.push_back(1'b1);
        withhold = 1;
        launch(3);
        wait_done("ur");
        check_frame("ur");
        check("ur_err", err, 1);
        check("ur_hs", hs_cnt - hs_base, 1);
        withhold = 0;
        src.delete();
        pop_pend = 0;

        // next start clears err; a start during DATA is ignored
        fill_random(4);
        build_exp();
        launch(4);
        check("clr_err", err, 0);
        for (int i = 0; i < 2000 && cap.size() < 6; i++) @(posedge clk);
        #2;
        blklen = BW'(1);
        start  = 1'b1;
        @(posedge clk); #2;
        start  = 1'b0;
        wait_done("ign");
        check_frame("ign");
        check("ign_hs", hs_cnt - hs_base, 4);
        check("ign_err", err, 0);

        // reset in the middle of the CRC field
        fill_random(2);
        launch(2);
        for (int i = 0; i < 2000 && cap.size() < 1 + 16 + 4; i++) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rstcrc_oe", oe, 0);
        check("rstcrc_dat", dat, 1);
        check("rstcrc_busy", busy, 0);
        check("rstcrc_ready", byte_ready, 0);
        @(posedge clk); #2;
        rstn = 1'b1;
        src.delete();
        pop_pend = 0;
        repeat (4) @(posedge clk);
        #2;
        check("after_rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
